// File: rtl/cipher_cfg_pkg.sv
// Shared types and constants for the cipher configuration loader.
package cipher_cfg_pkg;

   localparam int CIPHER_KEY_W = 32;
   localparam int CFG_BYTE_W   = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      LOAD    = 2'd2,
      VERIFY  = 2'd3
   } cfg_state_t;

endpackage

// File: rtl/cfg_key_shreg.sv
// Key holding register: byte-parallel load at a byte index (MSB byte = index 0),
// MSB-first serial output, recirculating on shift so the key survives a pass.
module cfg_key_shreg
   import cipher_cfg_pkg::*;
#(
   parameter int M    = CIPHER_KEY_W,
   parameter int IDXW = $clog2(M / CFG_BYTE_W) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [IDXW-1:0]       i_idx,
   input  logic [CFG_BYTE_W-1:0] i_byte,
   input  logic                  i_shift,
   output logic                  o_msb
);

   localparam int NB = M / CFG_BYTE_W;

   logic [M-1:0] r_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key <= '0;
      end else if (i_shift) begin
         r_key <= {r_key[M-2:0], r_key[M-1]};
      end else if (i_load) begin
         for (int i = 0; i < NB; i++) begin
            if (i_idx == IDXW'(i)) begin
               r_key[M-1-CFG_BYTE_W*i -: CFG_BYTE_W] <= i_byte;
            end
         end
      end
   end

   assign o_msb = r_key[M-1];

endmodule

// File: rtl/cipher_cfg_loader.sv
// Byte-stream key collector and serial loader for the cipher cfg chain.
// Optional read-back pass enabled by CIPHER_CFG_LOADER_VERIFY_EN.
//
// state   | meaning
// IDLE    | waiting for first key byte; key_valid reflects last load
// COLLECT | accepting remaining key bytes, MSB byte first
// LOAD    | M cycles shifting key into the chain, MSB first
// VERIFY  | M more cycles re-shifting while comparing chain tail
module cipher_cfg_loader
   import cipher_cfg_pkg::*;
#(
   parameter int M = CIPHER_KEY_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CFG_BYTE_W-1:0] byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   input  logic                  abort_i,
   output logic                  cfg_en_o,
   output logic                  cfg_o,
   input  logic                  cfg_ret_i,
   output logic                  key_valid_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int NB  = M / CFG_BYTE_W;
   localparam int BCW = $clog2(NB) + 1;
   localparam int BW  = $clog2(M);

   cfg_state_t r_state, w_state_nxt;
   logic [BCW-1:0] r_byte_cnt, w_byte_cnt_nxt;
   logic [BW-1:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic r_cfg_en, w_cfg_en_nxt;
   logic r_key_valid, w_key_valid_nxt;
   logic r_done, w_done_nxt;
   logic w_accept, w_load_byte, w_shift, w_key_msb, w_pass_end;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
   logic r_err, w_err_nxt;
   logic r_flag, w_flag_nxt;
`else
   logic w_unused_ret;
   assign w_unused_ret = cfg_ret_i;
`endif

   assign byte_ready_o = (r_state == IDLE) || (r_state == COLLECT);
   assign busy_o       = (r_state != IDLE);
   assign w_accept     = byte_valid_i && byte_ready_o;
   assign w_pass_end   = (r_bit_cnt == BW'(M - 1));

   always_comb begin
      w_state_nxt     = r_state;
      w_byte_cnt_nxt  = r_byte_cnt;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_key_valid_nxt = r_key_valid;
      w_done_nxt      = 1'b0;
      w_load_byte     = 1'b0;
      w_shift         = 1'b0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
      w_err_nxt       = r_err;
      w_flag_nxt      = r_flag;
`endif
      if (abort_i) begin
         w_state_nxt     = IDLE;
         w_key_valid_nxt = 1'b0;
         w_byte_cnt_nxt  = '0;
         w_bit_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE, COLLECT: begin
               if (w_accept) begin
                  w_load_byte = 1'b1;
                  if (r_state == IDLE) begin
                     w_key_valid_nxt = 1'b0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                     w_err_nxt       = 1'b0;
`endif
                  end
                  if (r_byte_cnt == BCW'(NB - 1)) begin
                     w_state_nxt    = LOAD;
                     w_byte_cnt_nxt = '0;
                     w_bit_cnt_nxt  = '0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                     w_flag_nxt     = 1'b0;
`endif
                  end else begin
                     w_state_nxt    = COLLECT;
                     w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                  end
               end
            end
            LOAD: begin
               w_shift       = 1'b1;
               w_bit_cnt_nxt = w_pass_end ? '0 : r_bit_cnt + 1'b1;
               if (w_pass_end) begin
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                  w_state_nxt = VERIFY;
`else
                  w_state_nxt     = IDLE;
                  w_done_nxt      = 1'b1;
                  w_key_valid_nxt = 1'b1;
`endif
               end
            end
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
            VERIFY: begin
               // chain tail is combinational, so it lines up with the bit being re-sent
               w_shift       = 1'b1;
               w_flag_nxt    = r_flag | (cfg_ret_i != w_key_msb);
               w_bit_cnt_nxt = w_pass_end ? '0 : r_bit_cnt + 1'b1;
               if (w_pass_end) begin
                  w_state_nxt     = IDLE;
                  w_done_nxt      = 1'b1;
                  w_err_nxt       = w_flag_nxt;
                  w_key_valid_nxt = !w_flag_nxt;
               end
            end
`endif
            default: w_state_nxt = IDLE;
         endcase
      end
      w_cfg_en_nxt = (w_state_nxt == LOAD) || (w_state_nxt == VERIFY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_byte_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_cfg_en    <= 1'b0;
         r_key_valid <= 1'b0;
         r_done      <= 1'b0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
         r_err       <= 1'b0;
         r_flag      <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_byte_cnt  <= w_byte_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_cfg_en    <= w_cfg_en_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_done      <= w_done_nxt;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
         r_err       <= w_err_nxt;
         r_flag      <= w_flag_nxt;
`endif
      end
   end

   cfg_key_shreg #(
      .M    (M),
      .IDXW (BCW)
   ) u_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load_byte),
      .i_idx   (r_byte_cnt),
      .i_byte  (byte_i),
      .i_shift (w_shift),
      .o_msb   (w_key_msb)
   );

   assign cfg_en_o    = r_cfg_en;
   assign cfg_o       = w_key_msb;
   assign key_valid_o = r_key_valid;
   assign done_o      = r_done;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
   assign err_o       = r_err;
`else
   assign err_o       = 1'b0;
`endif

endmodule

// File: doc/cipher_cfg_loader.md
# cipher_cfg_loader

Upstream configuration stage for the dual XOR stream cipher. Accepts the M-bit key/seed as a byte stream, then shifts it serially into the cipher's configuration chain (`cfg_en`/`cfg_i`/`cfg_o`). An optional second pass reads the chain back and verifies it. While a load is in progress, the block holds the cipher's tx/rx enables low and only releases them after a successful load.

## Interface
- `M`, default 32: key width in bits and length of the cipher cfg chain; multiple of 8, minimum 8.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `byte_i`  in  8  key byte; first byte is the key MSB byte.
- `byte_valid_i`  in  1  `byte_i` valid.
- `byte_ready_o`  out  1  loader can accept a byte.
- `abort_i`  in  1  cancel any load in progress.
- `cfg_en_o`  out  1  drives cipher `cfg_en`.
- `cfg_o`  out  1  drives cipher `cfg_i`.
- `cfg_ret_i`  in  1  from cipher `cfg_o` (chain tail bit).
- `key_valid_o`  out  1  chain holds a fully loaded (and verified) key; gates cipher tx_en/rx_en.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle pulse at the end of a load.
- `err_o`  out  1  verify mismatch on the last load; sticky.

## Operation
- **States:** IDLE, COLLECT, LOAD, VERIFY.
- **IDLE:** `byte_ready_o`=1. An accepted byte (`byte_valid_i && byte_ready_o`) is stored at the top of the key register, then the FSM goes to COLLECT. That same accept clears `key_valid_o` and `err_o`.
- **COLLECT:** `byte_ready_o`=1. Bytes are stored MSB-byte first. After M/8 accepted bytes the FSM goes to LOAD.
- **LOAD:** `byte_ready_o`=0. `cfg_en_o`=1 for exactly M cycles. `cfg_o` presents key bits MSB first, one bit per cycle. The key register recirculates, so it still holds the key after M shifts.
- **VERIFY:** a further M cycles with `cfg_en_o`=1, re-shifting the same key MSB first.
  - The chain tail presents its bit combinationally, so `cfg_ret_i` in verify cycle k must equal key bit M-1-k.
  - Any mismatch sets an internal sticky flag.
  - At the end of the pass: `err_o` = flag, `key_valid_o` = !flag, `done_o` pulses, FSM returns to IDLE.
- **abort_i:** takes effect from any state. Next state is IDLE; `key_valid_o`=0; the byte count and bit count are cleared; `err_o` is unchanged; `done_o` does not pulse. `abort_i` has priority over a simultaneous byte accept.
- **Ignored input:** `byte_valid_i` during LOAD/VERIFY is ignored; no byte is consumed.
- **Counters:** the byte counter is clog2(M/8)+1 bits wide and the bit counter clog2(M) bits wide. The bit counter wraps to 0 at M-1, which marks a pass boundary.

## Timing
- **Reset values:** `byte_ready_o`=1, `cfg_en_o`=0, `cfg_o`=0, `key_valid_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0. The key register is cleared.
- **Load timeline:** let the last byte be accepted at cycle t.
  - `cfg_en_o`=1 for cycles t+1 … t+2M.
  - `done_o` and final `key_valid_o`/`err_o` appear at t+2M+1.
  - `byte_ready_o` is 1 again at t+2M+1.
- **Outputs are registered:** `cfg_en_o` and `cfg_o` change only on `clk`.
- **Reset mid-LOAD/VERIFY:** `cfg_en_o` drops asynchronously. The chain contents are then undefined, and `key_valid_o`=0 makes this safe.
- **Back-to-back loads:** a new first byte is accepted in the same cycle `done_o` pulses (IDLE, ready=1). Its accept clears `key_valid_o` on the next edge.

## Configuration
- **Macro:** `CIPHER_CFG_LOADER_VERIFY_EN`.
- **Defined:** the VERIFY state is present, with the timing given above.
- **Undefined:**
  - VERIFY is removed; LOAD goes straight to IDLE.
  - `done_o` and `key_valid_o`=1 appear at t+M+1.
  - `cfg_en_o` is high for M cycles.
  - `err_o` is tied to 0.
  - `cfg_ret_i` is unused.

## Structure
- **Package `cipher_cfg_pkg`:** state enum `cfg_state_t` (IDLE, COLLECT, LOAD, VERIFY), default key width constant `CIPHER_KEY_W`=32, byte width constant 8.
- **Sub-module `cfg_key_shreg`:**
  - M-bit register with byte-parallel load and MSB-first serial output.
  - Recirculates on shift.
  - Controlled by the loader FSM.

## Test plan
- **Basic load, verify on:**
  - Stimulus: bytes DE AD BE EF, with a 32-bit shift-register model on the chain.
  - Expected: `cfg_o` sequence 0xDEADBEEF MSB first; `cfg_en_o` high 64 cycles; `done_o` at t+65; `key_valid_o`=1, `err_o`=0.
- **Corrupted readback:** `cfg_ret_i` stuck at 0 with key 0x00000001 → `err_o`=1 and `key_valid_o`=0 at t+65.
- **Backpressure:** `byte_valid_i` held high with byte 0x55 throughout LOAD → `byte_ready_o`=0, no byte consumed, chain ends 0xDEADBEEF.
- **Abort:**
  - Stimulus: `abort_i` at LOAD cycle 10.
  - Expected: IDLE next cycle, `cfg_en_o`=0, no `done_o`, `key_valid_o`=0.
  - Follow-up: a fresh 4-byte load completes normally.
- **Reset mid-VERIFY:**
  - Stimulus: `rst_n` low at verify cycle 5.
  - Expected: all outputs at reset values immediately; `byte_ready_o`=1 after release.
- **Macro undefined:** same load as the basic case → `cfg_en_o` high 32 cycles, `done_o` at t+33, `err_o`=0 even with `cfg_ret_i` stuck.
